// File: rtl/vedic_pkg.sv
// vedic_pkg -- shared constants, helpers and stage record for the Vedic multiplier.
// Rev 1.0
`default_nettype none

package vedic_pkg;

  localparam int VMUL_LATENCY = 3;

  function automatic int half_w(input int width);
    return width / 2;
  endfunction

  // Control half of a pipeline stage; the tag travels in its own register
  // because its width is a parameter of the instantiating module.
  typedef struct packed {
    logic valid;
    logic negate;
  } stage_ctl_t;

endpackage

`default_nettype wire

// File: rtl/vedic_mul_core.sv
// vedic_mul_core -- combinational unsigned N x N Vedic (Urdhva-Tiryagbhyam) multiplier.
// Rev 1.0
`default_nettype none

module vedic_mul_core
  import vedic_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);

  if (N <= 4) begin : g_leaf
    assign p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
  end else begin : g_split
    localparam int H = half_w(N);

    logic [N-1:0]   ll, hl, lh, hh;
    logic [2*N-1:0] x, y, z, s, c;

    vedic_mul_core #(.N(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(ll));
    vedic_mul_core #(.N(H)) u_hl (.a(a[N-1:H]), .b(b[H-1:0]), .p(hl));
    vedic_mul_core #(.N(H)) u_lh (.a(a[H-1:0]), .b(b[N-1:H]), .p(lh));
    vedic_mul_core #(.N(H)) u_hh (.a(a[N-1:H]), .b(b[N-1:H]), .p(hh));

    // LL and HH never overlap, so they share one CSA input.
    assign x = {hh, ll};
    assign y = {{H{1'b0}}, hl, {H{1'b0}}};
    assign z = {{H{1'b0}}, lh, {H{1'b0}}};
    assign s = x ^ y ^ z;
    assign c = ((x & y) | (x & z) | (y & z)) << 1;
    assign p = s + c;
  end

endmodule

`default_nettype wire

// File: rtl/vedic_mul_pipe.sv
// vedic_mul_pipe -- 3-stage pipelined signed/unsigned Vedic multiplier with valid/ready.
// Rev 1.0
`default_nettype none

module vedic_mul_pipe
  import vedic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
);

  localparam int H  = half_w(WIDTH);
  localparam int PW = 2 * WIDTH;

  stage_ctl_t       s1_ctl, s2_ctl, s3_ctl;
  logic [TAG_W-1:0] s1_tag, s2_tag, s3_tag;
  logic [WIDTH-1:0] s1_ma, s1_mb;
  logic [PW-1:0]    s2_sum, s2_carry, s3_p;

  logic             adv, accept, neg_a, neg_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] pp_ll, pp_hl, pp_lh, pp_hh;
  logic [PW-1:0]    t0, t1, t2, pp_sum, pp_carry, total, resolved;

  // The whole pipe freezes on backpressure; bubbles are never squeezed out.
  assign adv      = ~s3_ctl.valid | out_ready;
  assign in_ready = adv & ~rst;
  assign accept   = in_valid & in_ready;

  assign neg_a = in_signed & in_a[WIDTH-1];
  assign neg_b = in_signed & in_b[WIDTH-1];
  assign mag_a = neg_a ? -in_a : in_a;
  assign mag_b = neg_b ? -in_b : in_b;

  vedic_mul_core #(.N(H)) u_pp_ll (.a(s1_ma[H-1:0]),     .b(s1_mb[H-1:0]),     .p(pp_ll));
  vedic_mul_core #(.N(H)) u_pp_hl (.a(s1_ma[WIDTH-1:H]), .b(s1_mb[H-1:0]),     .p(pp_hl));
  vedic_mul_core #(.N(H)) u_pp_lh (.a(s1_ma[H-1:0]),     .b(s1_mb[WIDTH-1:H]), .p(pp_lh));
  vedic_mul_core #(.N(H)) u_pp_hh (.a(s1_ma[WIDTH-1:H]), .b(s1_mb[WIDTH-1:H]), .p(pp_hh));

  assign t0       = {pp_hh, pp_ll};
  assign t1       = {{H{1'b0}}, pp_hl, {H{1'b0}}};
  assign t2       = {{H{1'b0}}, pp_lh, {H{1'b0}}};
  assign pp_sum   = t0 ^ t1 ^ t2;
  assign pp_carry = (t0 & t1) | (t0 & t2) | (t1 & t2);

  assign total    = s2_sum + (s2_carry << 1);
  assign resolved = s2_ctl.negate ? -total : total;

  always_ff @(posedge clk) begin
    if (adv) begin
      s1_ma    <= mag_a;
      s1_mb    <= mag_b;
      s1_tag   <= in_tag;
      s2_sum   <= pp_sum;
      s2_carry <= pp_carry;
      s2_tag   <= s1_tag;
    end
  end

  // Output data loads only from a valid S2 entry so out_p never picks up
  // unreset S2 contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_ctl <= '0;
      s2_ctl <= '0;
      s3_ctl <= '0;
      s3_p   <= '0;
      s3_tag <= '0;
    end else if (adv) begin
      s1_ctl.valid  <= accept;
      s1_ctl.negate <= neg_a ^ neg_b;
      s2_ctl        <= s1_ctl;
      s3_ctl        <= s2_ctl;
      if (s2_ctl.valid) begin
        s3_p   <= resolved;
        s3_tag <= s2_tag;
      end
    end
  end

  assign out_valid = s3_ctl.valid;
  assign out_p     = s3_p;
  assign out_tag   = s3_tag;
  assign busy      = s1_ctl.valid | s2_ctl.valid | s3_ctl.valid;

endmodule

`default_nettype wire

// File: tb/tb_vedic_mul_pipe.sv
// tb_vedic_mul_pipe -- self-checking bench for vedic_mul_pipe (WIDTH 32 plus 8/16/64 sweep).
// Rev 1.0
`default_nettype none

module tb_vedic_mul_pipe;

  localparam int W  = 32;
  localparam int TW = 4;
  localparam int NS = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid, in_signed, out_ready;
  logic [W-1:0]  in_a, in_b;
  logic [TW-1:0] in_tag;
  logic          in_ready, out_valid, busy;
  logic [2*W-1:0] out_p;
  logic [TW-1:0] out_tag;

  vedic_mul_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
    .out_tag(out_tag), .busy(busy)
  );

  // Width sweep: three extra instances driven from the main process.
  logic          sw_rst;
  logic [63:0]   sw_a [3];
  logic [63:0]   sw_b [3];
  logic          sw_v [3];
  logic          sw_s [3];
  logic          sw_or[3];
  logic [3:0]    sw_tag[3];
  logic          sw_ir[3];
  logic          sw_ov[3];
  logic          sw_busy[3];
  logic [127:0]  sw_p [3];
  logic [3:0]    sw_ot[3];

  function automatic int sweep_w(input int g);
    return (g == 0) ? 8 : (g == 1) ? 16 : 64;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int SWW = (g == 0) ? 8 : (g == 1) ? 16 : 64;
    logic [2*SWW-1:0] p_w;
    logic [3:0]       ot_w;
    logic             ir_w, ov_w, busy_w;

    vedic_mul_pipe #(.WIDTH(SWW), .TAG_W(4)) u_dut (
      .clk(clk), .rst(sw_rst), .in_valid(sw_v[g]), .in_ready(ir_w),
      .in_a(sw_a[g][SWW-1:0]), .in_b(sw_b[g][SWW-1:0]), .in_signed(sw_s[g]),
      .in_tag(sw_tag[g]), .out_valid(ov_w), .out_ready(sw_or[g]), .out_p(p_w),
      .out_tag(ot_w), .busy(busy_w)
    );

    assign sw_p[g]    = 128'(p_w);
    assign sw_ot[g]   = ot_w;
    assign sw_ir[g]   = ir_w;
    assign sw_ov[g]   = ov_w;
    assign sw_busy[g] = busy_w;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: extend each operand to 128 bits by its signedness, multiply, keep 2w bits.
  function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                           input logic sgn, input int w);
    logic [127:0] ea, eb, mask;
    ea = {64'b0, a};
    eb = {64'b0, b};
    if (sgn && a[w-1]) ea = ea | (~128'b0 << w);
    if (sgn && b[w-1]) eb = eb | (~128'b0 << w);
    mask = (w == 64) ? ~128'b0 : ((128'b1 << (2 * w)) - 128'b1);
    return (ea * eb) & mask;
  endfunction

  function automatic logic [63:0] rnd(input int w);
    logic [63:0] m, r;
    m = (w == 64) ? ~64'b0 : ((64'b1 << w) - 64'b1);
    case ($urandom_range(0, 9))
      0:       r = 64'b0;
      1:       r = m;
      2:       r = 64'b1 << (w - 1);
      3:       r = 64'b1;
      4:       r = m >> 1;
      default: r = {$urandom, $urandom};
    endcase
    return r & m;
  endfunction

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [3:0]  tag;
    logic [63:0] p;
  } vec_t;

  vec_t vt[11];

  task automatic run_stream(input int nb, input int st_at, input int st_len);
    logic [63:0]  qp[$];
    logic [3:0]   qt[$];
    logic [63:0]  ra, rb, hp;
    logic [127:0] full;
    logic [3:0]   ht;
    logic         have, held;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0; have = 1'b0; held = 1'b0; hp = '0; ht = '0;
    while (got < nb && cyc < nb + st_len + 50) begin
      out_ready = !(cyc >= st_at && cyc < st_at + st_len);
      if (!have && sent < nb) begin
        ra = rnd(32); rb = rnd(32);
        in_a = ra[31:0]; in_b = rb[31:0];
        in_signed = 1'($urandom_range(0, 1));
        in_tag = 4'($urandom);
        have = 1'b1;
      end
      in_valid = have;
      #1;
      check("in_ready_rule", in_ready, !out_valid || out_ready);
      if (out_valid) begin
        if (held) begin
          check("hold_p", out_p, hp);
          check("hold_tag", out_tag, ht);
        end
        if (out_ready) begin
          check("result_expected", qp.size() != 0, 1);
          if (qp.size() != 0) begin
            check("stream_p", out_p, qp.pop_front());
            check("stream_tag", out_tag, qt.pop_front());
          end
          got++;
          held = 1'b0;
        end else begin
          held = 1'b1; hp = out_p; ht = out_tag;
        end
      end
      if (in_valid && in_ready) begin
        full = ref_mul({32'b0, in_a}, {32'b0, in_b}, in_signed, 32);
        qp.push_back(full[63:0]);
        qt.push_back(in_tag);
        sent++;
        have = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stream_cycles", cyc, nb + 3 + st_len);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] sq [3][$];
    logic [3:0]   stq[3][$];
    int sent[3], got[3];
    logic have[3];
    int lat, cyc, w;
    logic bsy_ok, seen;
    logic [63:0] ra;

    vt[0]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 4'd5, 64'hFFFFFFFE00000001};
    vt[1]  = '{32'h80000000, 32'h80000000, 1'b1, 4'd1, 64'h4000000000000000};
    vt[2]  = '{32'hFFFFFFFF, 32'h00000007, 1'b1, 4'd2, 64'hFFFFFFFFFFFFFFF9};
    vt[3]  = '{32'h00000000, 32'h80000000, 1'b1, 4'd3, 64'h0000000000000000};
    vt[4]  = '{32'h80000000, 32'h80000000, 1'b0, 4'd4, 64'h4000000000000000};
    vt[5]  = '{32'hFFFFFFFF, 32'h00000007, 1'b0, 4'd6, 64'h00000006FFFFFFF9};
    vt[6]  = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 4'd7, 64'hC000000080000000};
    vt[7]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 4'd8, 64'h3FFFFFFF00000001};
    vt[8]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 4'd9, 64'h0000000000000001};
    vt[9]  = '{32'hFFFF0000, 32'h00010000, 1'b1, 4'hA, 64'hFFFFFFFF00000000};
    vt[10] = '{32'h00010000, 32'h00010000, 1'b0, 4'hB, 64'h0000000100000000};

    rst = 1'b1; sw_rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; in_tag = '0; out_ready = 1'b1;
    for (int g = 0; g < 3; g++) begin
      sw_a[g] = '0; sw_b[g] = '0; sw_v[g] = 1'b0; sw_s[g] = 1'b0; sw_or[g] = 1'b1; sw_tag[g] = '0;
    end

    // Reset state
    tick();
    check("in_ready_in_rst", in_ready, 0);
    tick();
    rst = 1'b0; sw_rst = 1'b0;
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_p", out_p, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);

    // Single ops from the table: latency, busy window, product and tag
    for (int i = 0; i < 11; i++) begin
      in_a = vt[i].a; in_b = vt[i].b; in_signed = vt[i].sgn; in_tag = vt[i].tag;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 1;
      bsy_ok = 1'b1;
      while (!out_valid && lat < 8) begin
        if (!busy) bsy_ok = 1'b0;
        tick();
        lat++;
      end
      check("latency", lat, 3);
      check("busy_in_flight", bsy_ok & busy, 1);
      check("vec_p", out_p, vt[i].p);
      check("vec_tag", out_tag, vt[i].tag);
      tick();
      check("busy_after", busy, 0);
    end

    // Back-to-back throughput, then backpressure mid-stream
    run_stream(100, 1000, 0);
    run_stream(60, 20, 10);

    // Reset with three beats in flight; none may ever be delivered
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ra = rnd(32); in_a = ra[31:0];
      ra = rnd(32); in_b = ra[31:0];
      in_signed = 1'($urandom_range(0, 1)); in_tag = 4'(k);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("in_ready_midrst", in_ready, 0);
    tick();
    rst = 1'b0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_out_p", out_p, 0);
    out_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_ghost", seen, 0);

    // Width sweep with random gaps and random backpressure
    for (int g = 0; g < 3; g++) begin
      sent[g] = 0; got[g] = 0; have[g] = 1'b0;
    end
    cyc = 0;
    while ((got[0] < NS || got[1] < NS || got[2] < NS) && cyc < 4 * NS) begin
      for (int g = 0; g < 3; g++) begin
        w = sweep_w(g);
        sw_or[g] = ($urandom_range(0, 3) != 0);
        if (!have[g] && sent[g] < NS && $urandom_range(0, 7) != 0) begin
          sw_a[g] = rnd(w); sw_b[g] = rnd(w);
          sw_s[g] = 1'($urandom_range(0, 1)); sw_tag[g] = 4'($urandom);
          have[g] = 1'b1;
        end
        sw_v[g] = have[g];
      end
      #1;
      for (int g = 0; g < 3; g++) begin
        w = sweep_w(g);
        if (sw_ov[g] && sw_or[g]) begin
          check($sformatf("sweep%0d_expected", w), sq[g].size() != 0, 1);
          if (sq[g].size() != 0) begin
            check($sformatf("sweep%0d_p", w), sw_p[g], sq[g].pop_front());
            check($sformatf("sweep%0d_tag", w), sw_ot[g], stq[g].pop_front());
          end
          got[g]++;
        end
        if (sw_v[g] && sw_ir[g]) begin
          sq[g].push_back(ref_mul(sw_a[g], sw_b[g], sw_s[g], w));
          stq[g].push_back(sw_tag[g]);
          sent[g]++;
          have[g] = 1'b0;
        end
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    for (int g = 0; g < 3; g++) begin
      sw_v[g] = 1'b0;
      check($sformatf("sweep%0d_count", sweep_w(g)), got[g], NS);
      check($sformatf("sweep%0d_idle", sweep_w(g)), sw_busy[g], 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
